// File: rtl/uav_timing_pkg.sv
// Shared timing definitions for the UAV clock divider and its receiving-side
// rate monitor: monitor state encoding and the default counter geometry.
package uav_timing_pkg;

  // Monitor states; the numeric encoding is fixed so the state can be decoded
  // by debug/status logic elsewhere.
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,  // no reference edge yet (after reset or after loss)
    S_MEAS = 2'd1,  // one edge seen, first period being measured
    S_LOCK = 2'd2   // at least one full period measured
  } mon_state_e;

  // Defaults shared with the divider: a 27-bit counter and a 2**26-cycle
  // timeout, which satisfies 2 <= TIMEOUT <= 2**CNT_W - 1.
  localparam int unsigned CNT_W_DEFAULT   = 27;
  localparam int unsigned TIMEOUT_DEFAULT = 2 ** 26;

endpackage : uav_timing_pkg

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain through a flop chain and
// flags its rising edges. The chain and the prev register always run so that
// an edge arriving while disabled is consumed rather than reported late.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by a one-cycle-delayed copy of its last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value from
      // before this edge, so the chain really is SYNC_STAGES flops deep.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised level, discarded while disabled.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & ena;

endmodule : sync_edge_detect

// File: rtl/clock_rate_monitor.sv
// Receives a divided clock/strobe from elsewhere in the design, turns each of
// its rising edges into a one-cycle clk-domain tick, measures its period in
// clk cycles and flags loss of the input after TIMEOUT quiet cycles.
module clock_rate_monitor
  import uav_timing_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             div_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost
);

  // Counter value seen in the last quiet cycle before loss is declared.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  mon_state_e       state;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   (div_in),
    .rise  (rise)
  );

  // Period of the edge just seen: cycles counted since the previous edge plus
  // the edge cycle itself. Cannot overflow because the timeout fires first.
  assign cnt_inc = cnt + CNT_W'(1);

  // Cycle counter: restarts on every edge, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (rise) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt_inc;
      end
    end
  end

  // Lock/loss state machine with registered tick, period and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      tick       <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      lost       <= 1'b0;
    end else begin
      // rise is already gated by ena, so tick drops to 0 while disabled.
      tick       <= rise;
      period_vld <= 1'b0;
      if (ena) begin
        unique case (state)
          S_WAIT: begin
            if (rise) begin
              state <= S_MEAS;
              lost  <= 1'b0;
            end
          end
          S_MEAS, S_LOCK: begin
            // An edge on the timeout cycle wins: the input is still alive.
            if (rise) begin
              state      <= S_LOCK;
              period     <= cnt_inc;
              period_vld <= 1'b1;
              locked     <= 1'b1;
            end else if (cnt == TIMEOUT_LAST) begin
              state  <= S_WAIT;
              lost   <= 1'b1;
              locked <= 1'b0;
            end
          end
          default: begin
            // NOTE: the unused encoding recovers to S_WAIT instead of holding,
            // so a corrupted state register cannot wedge the monitor.
            state  <= S_WAIT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : clock_rate_monitor

// File: doc/clock_rate_monitor.md
# clock_rate_monitor

Receiving-side counterpart to the UAV clock divider. It takes a divided clock or strobe generated elsewhere in the design, synchronises it into the system clock domain, and emits a one-cycle `tick` on each rising edge. It also measures the period of the divided clock in system-clock cycles and flags loss of the input. Downstream timing logic (PWM update, sensor polling) uses `tick` as a clock-enable instead of clocking flops from the divided clock.

## Interface
- `CNT_W`, 27: width of the period counter and of `period`.
- `SYNC_STAGES`, 2: number of synchroniser flops on `div_in`, minimum 2.
- `TIMEOUT`, 2**26: cycles without a rising edge before `lost` asserts. Must satisfy 2 ≤ TIMEOUT ≤ 2**CNT_W − 1.
- `clk` in 1: system clock; all logic is in this single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: monitor enable. While low, state, counter and outputs hold, and `tick`/`period_vld` are forced to 0.
- `div_in` in 1: divided clock, treated as asynchronous.
- `tick` out 1: one-cycle pulse per detected rising edge of `div_in`.
- `period` out CNT_W: clk cycles between the last two detected rising edges.
- `period_vld` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: at least one full period has been measured since the last reset or loss.
- `lost` out 1: level; no edge within TIMEOUT cycles while measuring.

## Operation
- **Synchroniser:** a SYNC_STAGES-deep flop chain on `div_in`. It runs regardless of `ena`. A prev-register follows the last sync stage.
- **Edge detect:** `rise = sync_last & ~prev & ena`. Edges that occur while `ena` = 0 are discarded.
- **Counter `cnt`:**
  - cleared to 0 on a `rise` cycle.
  - otherwise increments each `ena` cycle and saturates at all-ones (no wrap).
- **State machine** (encoding S_WAIT=0, S_MEAS=1, S_LOCK=2):
  - S_WAIT: on `rise` → S_MEAS, clear `cnt`, clear `lost`.
  - S_MEAS: on `rise` → S_LOCK, `period <= cnt+1`, pulse `period_vld`, set `locked`.
  - S_LOCK: on `rise` → stay, `period <= cnt+1`, pulse `period_vld`.
  - S_MEAS or S_LOCK with no `rise` and `cnt == TIMEOUT−1` → S_WAIT, set `lost`, clear `locked`. `period` retains its last value.
  - If `rise` and the timeout condition occur in the same cycle, `rise` wins and no loss is flagged.
- **`tick`:** registered copy of `rise`, asserted in every state, including the first edge after reset.
- **Arithmetic:** `cnt+1` is computed at CNT_W bits. Because TIMEOUT ≤ 2**CNT_W − 1, it never overflows before the timeout fires.
- **Reset mid-operation:** everything returns to reset values immediately and any in-progress measurement is discarded.

## Timing
- **Reset values:** `tick`=0, `period`=0, `period_vld`=0, `locked`=0, `lost`=0, state S_WAIT, `cnt`=0, sync chain and prev = 0.
- **Edge-to-tick latency:** suppose `div_in` is first sampled high at clk edge k and `ena` is held high. Then `rise` is true in the cycle after edge k+SYNC_STAGES−1. `tick`, `period_vld` and the `period` update appear after edge k+SYNC_STAGES, which is 3 edges for the default.
- **Alignment:** `period_vld` and `tick` coincide on the same cycle. `period` is stable from that cycle until the next update.
- **Measurement range:** for a steady input of period P cycles (2 ≤ P < TIMEOUT), every `period_vld` reports exactly P.
- **Loss timing:** `lost` rises TIMEOUT cycles after the last `rise` and is held until the next `rise`. On that `rise` `lost` clears, and the block re-enters S_MEAS with `locked` = 0.
- **Fastest input:** clk/2 gives P=2, one tick every other cycle, and must be measured correctly.

## Structure
- Shared package `uav_timing_pkg` holds:
  - the state encoding constants S_WAIT, S_MEAS, S_LOCK;
  - the default CNT_W and TIMEOUT localparams shared with the divider.
- One natural sub-module: `sync_edge_detect` (synchroniser chain, prev-register and rise output), parameterised by SYNC_STAGES.

## Test plan
Bench parameters: CNT_W=8, TIMEOUT=100.
- **Steady input:** `div_in` period 10, `ena`=1.
  - First `tick` 3 cycles after the first rising edge, then one every 10 cycles.
  - First `period_vld` on the second tick, `period`=10, `locked`=1.
- **Fastest input:** `div_in` = clk/2. `period`=2 on every `period_vld`; `tick` every 2 cycles.
- **Loss and recovery:** after lock, hold `div_in` low.
  - `lost`=1 and `locked`=0 exactly 100 cycles after the last `rise`.
  - `period` keeps 10.
  - Restart the input: `lost` clears on the first tick and `locked` returns on the second.
- **Timeout boundary:** edges exactly 100 cycles apart give no `lost` and `period`=100. Edges 101 cycles apart give `lost` pulses and no lock.
- **Enable gating:** drop `ena` for 25 cycles spanning two edges.
  - No `tick`, and `cnt` frozen.
  - On re-enable, the next `period` reflects enabled cycles only.
- **Reset mid-measurement:** assert `rst_n`=0 in S_LOCK for 1 cycle. All outputs read 0 immediately, and two edges are needed before `locked`=1 again.
